// File: rtl/code_loader_pkg.sv
// Shared definitions for the code loader: FSM states, frame marker,
// the code word type and the per-state output decode.
package code_loader_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Code word as stored in code storage.
    localparam int CODE_W = 12;
    typedef logic [CODE_W-1:0] code_word_t;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        START,
        RUN,
        ERROR
    } state_t;

    // Control outputs, all derived from the state the FSM is entering.
    typedef struct packed {
        logic ready;
        logic busy;
        logic active;
        logic error;
        logic pc_reset;
        logic is_write;
    } ctl_t;

    // Output decode for a given state; registered by the FSM so every
    // control output is a flop.
    function automatic ctl_t state_outputs(input state_t s);
        ctl_t c;
        c          = '0;
        c.ready    = (s != WRITE) && (s != START);
        c.busy     = (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
                     (s == DATA_HI) || (s == WRITE) || (s == START);
        c.active   = (s == RUN);
        c.error    = (s == ERROR);
        c.pc_reset = (s == START);
        c.is_write = (s == WRITE);
        return c;
    endfunction

    // Low byte supplies bits 7:0, low nibble of the high byte supplies 11:8.
    function automatic code_word_t assemble_word(input logic [7:0] lo, input logic [7:0] hi);
        return {hi[3:0], lo};
    endfunction

endpackage

// File: rtl/code_loader.sv
// Host-side code loader: parses a framed byte stream (sync, 16-bit count,
// little-endian 12-bit words), writes each word to sequential code storage
// lines, then pulses the program-counter reset and holds execution active.
module code_loader #(
    parameter int         DATA_WIDTH = 12,
    parameter int         LINE_WIDTH = 32,
    parameter int         DEPTH      = 256,
    parameter logic [7:0] SYNC_BYTE  = code_loader_pkg::SYNC_BYTE
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  host_in_valid,
    input  logic [7:0]            host_in_data,
    output logic                  host_in_ready,
    input  logic                  load_abort,
    output logic [LINE_WIDTH-1:0] code_storage_write_interface_write_line,
    output logic [DATA_WIDTH-1:0] code_storage_write_interface_write_data,
    output logic                  code_storage_write_interface_is_write,
    output logic                  code_storage_code_control_interface_reset,
    output logic                  code_storage_code_control_interface_active,
    output logic                  busy,
    output logic                  error,
    output logic [15:0]           words_loaded
);
    import code_loader_pkg::*;

    localparam logic [15:0] DEPTH_N = 16'(DEPTH);

    state_t                r_state;
    state_t                w_next;
    ctl_t                  r_ctl;
    logic [7:0]            r_len_lo;
    logic [7:0]            r_data_lo;
    logic [15:0]           r_count;
    logic [15:0]           r_index;
    logic [15:0]           r_words;
    logic [LINE_WIDTH-1:0] r_wr_line;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_take;
    logic                  w_sync;
    logic [15:0]           w_len;
    logic                  w_len_bad;
    logic                  w_last;
    logic                  w_frame_start;

    // Abort wins over the handshake: a byte offered alongside abort is dropped.
    assign w_take        = host_in_valid && r_ctl.ready && !load_abort;
    assign w_sync        = w_take && (host_in_data == SYNC_BYTE);
    assign w_len         = {host_in_data, r_len_lo};
    assign w_len_bad     = (w_len == 16'd0) || (w_len > DEPTH_N);
    assign w_last        = (r_index == (r_count - 16'd1));
    assign w_frame_start = w_sync && ((r_state == IDLE) || (r_state == RUN));

    // Next-state decode for the frame parser.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_sync) w_next = LEN_LO;
            LEN_LO:  if (w_take) w_next = LEN_HI;
            LEN_HI:  if (w_take) w_next = w_len_bad ? ERROR : DATA_LO;
            DATA_LO: if (w_take) w_next = DATA_HI;
            DATA_HI: if (w_take) w_next = WRITE;
            WRITE:   w_next = w_last ? START : DATA_LO;
            START:   w_next = RUN;
            RUN:     if (w_sync) w_next = LEN_LO;
            ERROR:   w_next = ERROR;
            default: w_next = IDLE;
        endcase
        if (load_abort) w_next = IDLE;
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= IDLE;
            r_ctl   <= state_outputs(IDLE);
        end else begin
            r_state <= w_next;
            r_ctl   <= state_outputs(w_next);
        end
    end

    // Length capture, word assembly, line index and word counter.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_len_lo  <= '0;
            r_data_lo <= '0;
            r_count   <= '0;
            r_index   <= '0;
            r_words   <= '0;
            r_wr_line <= '0;
            r_wr_data <= '0;
        end else if (!load_abort) begin
            if (w_frame_start) r_words <= '0;
            case (r_state)
                LEN_LO: if (w_take) r_len_lo <= host_in_data;
                LEN_HI: begin
                    if (w_take) begin
                        r_count <= w_len;
                        r_index <= '0;
                    end
                end
                DATA_LO: if (w_take) r_data_lo <= host_in_data;
                DATA_HI: begin
                    // Line and data are presented during WRITE and then held.
                    if (w_take) begin
                        r_wr_line <= LINE_WIDTH'(r_index);
                        r_wr_data <= DATA_WIDTH'(assemble_word(r_data_lo, host_in_data));
                    end
                end
                WRITE: begin
                    r_index <= r_index + 16'd1;
                    r_words <= r_words + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign host_in_ready                              = r_ctl.ready;
    assign busy                                       = r_ctl.busy;
    assign error                                      = r_ctl.error;
    assign code_storage_write_interface_is_write      = r_ctl.is_write;
    assign code_storage_code_control_interface_reset  = r_ctl.pc_reset;
    assign code_storage_code_control_interface_active = r_ctl.active;
    assign code_storage_write_interface_write_line    = r_wr_line;
    assign code_storage_write_interface_write_data    = r_wr_data;
    assign words_loaded                               = r_words;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: table-driven frames, hand-written
// timing sequences and randomized frames against a frame-level model.
module tb_code_loader;
    localparam int DW    = 12;
    localparam int LW    = 32;
    localparam int DEPTH = 256;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b0;
    logic          host_in_valid = 1'b0;
    logic [7:0]    host_in_data = 8'h00;
    logic          host_in_ready;
    logic          load_abort = 1'b0;
    logic [LW-1:0] wl;
    logic [DW-1:0] wd;
    logic          wr, pcr, act, busy, error;
    logic [15:0]   words_loaded;

    always #5 clk_clk = ~clk_clk;

    code_loader #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .host_in_valid(host_in_valid),
        .host_in_data(host_in_data),
        .host_in_ready(host_in_ready),
        .load_abort(load_abort),
        .code_storage_write_interface_write_line(wl),
        .code_storage_write_interface_write_data(wd),
        .code_storage_write_interface_is_write(wr),
        .code_storage_code_control_interface_reset(pcr),
        .code_storage_code_control_interface_active(act),
        .busy(busy),
        .error(error),
        .words_loaded(words_loaded)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Write monitor: every strobe observed is logged as {line, data}.
    typedef struct {int line; int data;} wr_t;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  pcr_cnt = 0;

    always @(negedge clk_clk) begin
        if (wr === 1'b1) got_q.push_back('{int'(wl), int'(wd)});
        if (pcr === 1'b1) pcr_cnt++;
    end

    // Bytes to transmit, and frame-level expectations.
    logic [7:0] tx_q[$];
    int exp_err, exp_act, exp_words, exp_pcr;

    // Reference: find the sync, read N, reject 0 or >DEPTH, else each byte
    // pair becomes word w at line w; the run ends active with N words.
    task automatic model_stream();
        int i = 0;
        int n;
        exp_q.delete();
        exp_err = 0; exp_act = 0; exp_words = 0; exp_pcr = 0;
        while (i < tx_q.size() && tx_q[i] != SYNC) i++;
        if (i + 2 >= tx_q.size()) return;
        n = {tx_q[i+2], tx_q[i+1]};
        if (n == 0 || n > DEPTH) begin
            exp_err = 1;
            return;
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back('{w, (int'(tx_q[i+4+2*w]) % 16) * 256 + int'(tx_q[i+3+2*w])});
        exp_words = n; exp_act = 1; exp_pcr = 1;
    endtask

    // Offer one byte; called just after a negedge, returns just after the
    // negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        host_in_valid = 1'b1;
        host_in_data  = b;
        while (host_in_ready !== 1'b1 && n < 50) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(host_in_ready), 32'd1);
        @(negedge clk_clk);
        host_in_valid = 1'b0;
    endtask

    task automatic send_q(input bit stall);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (stall) repeat ($urandom_range(0, 2)) @(negedge clk_clk);
            send_byte(tx_q[i]);
        end
        tx_q.delete();
    endtask

    task automatic go_idle();
        @(negedge clk_clk);
        host_in_valid = 1'b0;
        load_abort    = 1'b1;
        @(negedge clk_clk);
        load_abort    = 1'b0;
        got_q.delete();
        pcr_cnt = 0;
    endtask

    task automatic compare_results(input string tag);
        int m;
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_line"}, got_q[i].line, exp_q[i].line);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
        end
        check({tag, "_error"}, 32'(error), exp_err);
        check({tag, "_active"}, 32'(act), exp_act);
        check({tag, "_words"}, 32'(words_loaded), exp_words);
        check({tag, "_pcr"}, pcr_cnt, exp_pcr);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_stream(input bit stall, input string tag);
        model_stream();
        send_q(stall);
        repeat (5) @(negedge clk_clk);
        compare_results(tag);
    endtask

    // Directed frames: bytes left-justified in b, expected words left-justified in data.
    typedef struct packed {
        int         nb;
        logic [95:0] b;
        int         nw;
        logic [35:0] data;
        logic       err;
        logic       act;
    } vec_t;
    localparam int NV = 5;
    vec_t vt [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{9, {8'hA5, 8'h03, 8'h00, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'h0F, 8'h00, 24'h0},
                  3, {12'h123, 12'hABC, 12'h00F}, 1'b0, 1'b1};
        vt[1] = '{8, {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h34, 8'hF2, 32'h0},
                  1, {12'h234, 24'h0}, 1'b0, 1'b1};
        vt[2] = '{3, {8'hA5, 8'h00, 8'h00, 72'h0}, 0, 36'h0, 1'b1, 1'b0};
        vt[3] = '{3, {8'hA5, 8'h01, 8'h01, 72'h0}, 0, 36'h0, 1'b1, 1'b0};
        vt[4] = '{5, {8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 56'h0}, 1, {12'hFFF, 24'h0}, 1'b0, 1'b1};

        // Reset state
        #1 reset_reset = 1'b1;
        repeat (2) @(negedge clk_clk);
        check("rst_ready", 32'(host_in_ready), 32'd1);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_pcr", 32'(pcr), 32'd0);
        check("rst_act", 32'(act), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_line", wl, 32'd0);
        check("rst_data", 32'(wd), 32'd0);
        reset_reset = 1'b0;
        @(negedge clk_clk);

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            go_idle();
            tx_q.delete();
            for (int i = 0; i < vt[v].nb; i++) tx_q.push_back(vt[v].b[95-8*i -: 8]);
            send_q(1'b0);
            repeat (5) @(negedge clk_clk);
            check($sformatf("vec%0d_nwrites", v), got_q.size(), vt[v].nw);
            for (int i = 0; i < vt[v].nw && i < got_q.size(); i++) begin
                check($sformatf("vec%0d_line", v), got_q[i].line, i);
                check($sformatf("vec%0d_data", v), got_q[i].data, 32'(vt[v].data[35-12*i -: 12]));
            end
            check($sformatf("vec%0d_err", v), 32'(error), 32'(vt[v].err));
            check($sformatf("vec%0d_act", v), 32'(act), 32'(vt[v].act));
            check($sformatf("vec%0d_words", v), 32'(words_loaded), vt[v].nw);
            check($sformatf("vec%0d_pcr", v), pcr_cnt, vt[v].act ? 1 : 0);
            go_idle();
            check($sformatf("vec%0d_abort_err", v), 32'(error), 32'd0);
            check($sformatf("vec%0d_abort_act", v), 32'(act), 32'd0);
            check($sformatf("vec%0d_abort_ready", v), 32'(host_in_ready), 32'd1);
            check($sformatf("vec%0d_abort_busy", v), 32'(busy), 32'd0);
        end

        // Host stall between low and high byte, then exact write latency
        go_idle();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h77};
        send_q(1'b0);
        for (int i = 0; i < 10; i++) begin
            check("stall_no_write", 32'(wr), 32'd0);
            @(negedge clk_clk);
        end
        host_in_valid = 1'b1;
        host_in_data  = 8'h05;
        @(negedge clk_clk);
        host_in_valid = 1'b0;
        check("lat_wr", 32'(wr), 32'd1);
        check("lat_line", wl, 32'd0);
        check("lat_data", 32'(wd), 32'h577);
        check("lat_ready", 32'(host_in_ready), 32'd0);
        @(negedge clk_clk);
        check("start_wr", 32'(wr), 32'd0);
        check("start_pcr", 32'(pcr), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold_data", 32'(wd), 32'h577);
        @(negedge clk_clk);
        check("run_act", 32'(act), 32'd1);
        check("run_pcr", 32'(pcr), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        check("run_words", 32'(words_loaded), 32'd1);

        // Reload from RUN: active drops one cycle after the sync byte
        host_in_valid = 1'b1;
        host_in_data  = SYNC;
        @(negedge clk_clk);
        host_in_valid = 1'b0;
        check("reload_act_drop", 32'(act), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        check("reload_words_clr", 32'(words_loaded), 32'd0);
        got_q.delete();
        pcr_cnt = 0;
        tx_q = '{8'h02, 8'h00, 8'hAB, 8'h00, 8'hDE, 8'h0C};
        send_q(1'b0);
        repeat (5) @(negedge clk_clk);
        check("reload_nwrites", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("reload_l0", got_q[0].line, 0);
            check("reload_d0", got_q[0].data, 32'h0AB);
            check("reload_l1", got_q[1].line, 1);
            check("reload_d1", got_q[1].data, 32'hCDE);
        end
        check("reload_pcr", pcr_cnt, 1);
        check("reload_act", 32'(act), 32'd1);
        check("reload_words", 32'(words_loaded), 32'd2);

        // Abort beats a byte offered in the same cycle
        go_idle();
        tx_q = '{8'hA5, 8'h02, 8'h00};
        send_q(1'b0);
        host_in_valid = 1'b1;
        host_in_data  = 8'h11;
        load_abort    = 1'b1;
        @(negedge clk_clk);
        host_in_valid = 1'b0;
        load_abort    = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(host_in_ready), 32'd1);
        got_q.delete();
        pcr_cnt = 0;
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h03};
        run_stream(1'b0, "after_abort");

        // Asynchronous reset while word 1 of 4 is being written
        go_idle();
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h01, 8'h22};
        send_q(1'b0);
        host_in_valid = 1'b1;
        host_in_data  = 8'h02;
        @(posedge clk_clk);
        #1;
        host_in_valid = 1'b0;
        check("mid_wr", 32'(wr), 32'd1);
        check("mid_line", wl, 32'd1);
        reset_reset = 1'b1;
        #1;
        check("arst_wr", 32'(wr), 32'd0);
        check("arst_ready", 32'(host_in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_line", wl, 32'd0);
        check("arst_data", 32'(wd), 32'd0);
        check("arst_words", 32'(words_loaded), 32'd0);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        got_q.delete();
        pcr_cnt = 0;
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        run_stream(1'b0, "post_arst");

        // Largest legal frame: last write lands on line DEPTH-1
        go_idle();
        tx_q = '{SYNC, 8'h00, 8'h01};
        for (int i = 0; i < 2 * DEPTH; i++) tx_q.push_back(8'($urandom));
        run_stream(1'b0, "max_frame");

        // Randomized frames with host stalls
        for (int it = 0; it < 25; it++) begin
            int n;
            int kind;
            logic [7:0] g;
            go_idle();
            tx_q.delete();
            repeat ($urandom_range(0, 3)) begin
                do g = 8'($urandom); while (g == SYNC);
                tx_q.push_back(g);
            end
            tx_q.push_back(SYNC);
            kind = $urandom_range(0, 9);
            if (kind == 0)      n = 0;
            else if (kind == 1) n = DEPTH + 1 + $urandom_range(0, 1000);
            else                n = $urandom_range(1, 6);
            tx_q.push_back(8'(n));
            tx_q.push_back(8'(n >> 8));
            if (n >= 1 && n <= DEPTH) begin
                for (int i = 0; i < 2 * n; i++) tx_q.push_back(8'($urandom));
            end else begin
                repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom));
            end
            run_stream(1'b1, $sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
